// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer and its prescaler.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_TICK_CYCLES = 50_000_000;
  localparam int SIM_TICK_CYCLES = 10;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the game FSM (master) and the countdown timer (slave).
// The pause signal exists only when TIMER_PAUSE_EN is defined.
interface countdown_timer_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic             abort;
  logic             mode_reload;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] remaining;
  logic             tick;
  logic             done;
  logic             busy;
`ifdef TIMER_PAUSE_EN
  logic             pause;

  modport master (
    output start, abort, mode_reload, load_val, pause,
    input  remaining, tick, done, busy
  );

  modport slave (
    input  start, abort, mode_reload, load_val, pause,
    output remaining, tick, done, busy
  );
`else
  modport master (
    output start, abort, mode_reload, load_val,
    input  remaining, tick, done, busy
  );

  modport slave (
    input  start, abort, mode_reload, load_val,
    output remaining, tick, done, busy
  );
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Clearable, enable-gated divide-by-TICK_CYCLES counter; o_wrap is high in the
// last counted cycle of each period, so the consumer registers it into a pulse.
module tick_prescaler #(
  parameter int TICK_CYCLES = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap
);

  localparam int                 PRESC_W = $clog2(TICK_CYCLES);
  localparam logic [PRESC_W-1:0] LAST    = PRESC_W'(TICK_CYCLES - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_wrap    = i_en & w_at_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable tick countdown with one-shot / auto-reload modes.
// Optional TIMER_PAUSE_EN adds a pause input that freezes counting in RUN.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  countdown_timer_if.slave   bus
);

  // state | meaning
  // IDLE  | stopped; remaining=0, prescaler held at 0
  // RUN   | counting ticks; busy=1

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_remaining, w_rem_nxt;
  logic [CNT_W-1:0] r_reload, w_reload_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_done, w_done_nxt;
  logic             w_presc_clr;
  logic             w_presc_en;
  logic             w_wrap;

`ifdef TIMER_PAUSE_EN
  assign w_presc_en = (r_state == RUN) & ~bus.pause;
`else
  assign w_presc_en = (r_state == RUN);
`endif

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_presc (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_clr   (w_presc_clr),
    .i_en    (w_presc_en),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_reload    <= '0;
      r_mode      <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_reload    <= w_reload_nxt;
      r_mode      <= w_mode_nxt;
      r_tick      <= w_tick_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_remaining;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_presc_clr  = 1'b0;

    if (bus.abort) begin
      if (r_state == RUN) begin
        w_state_nxt = IDLE;
        w_rem_nxt   = '0;
        w_presc_clr = 1'b1;
      end
    end else if (bus.start) begin
      w_presc_clr = 1'b1;
      if (bus.load_val != '0) begin
        w_state_nxt  = RUN;
        w_rem_nxt    = bus.load_val;
        w_reload_nxt = bus.load_val;
        w_mode_nxt   = bus.mode_reload;
      end else begin
        // Zero-length run completes immediately without entering RUN.
        w_state_nxt = IDLE;
        w_rem_nxt   = '0;
        w_done_nxt  = 1'b1;
      end
    end else if ((r_state == RUN) && w_wrap) begin
      w_tick_nxt = 1'b1;
      if (r_remaining <= CNT_W'(1)) begin
        w_done_nxt = 1'b1;
        if (r_mode) begin
          w_rem_nxt = r_reload;
        end else begin
          w_rem_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end else begin
        w_rem_nxt = r_remaining - CNT_W'(1);
      end
    end
  end

  assign bus.remaining = r_remaining;
  assign bus.tick      = r_tick;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at TICK_CYCLES=10, CNT_W=4.
module tb_countdown_timer;
  import timer_pkg::*;

  localparam int TC = SIM_TICK_CYCLES;
  localparam int CW = 4;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  countdown_timer_if #(.CNT_W(CW)) bus();

  countdown_timer #(
    .TICK_CYCLES (TC),
    .CNT_W       (CW)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic edges(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int rem, input bit tk, input bit dn, input bit bz);
    chk({tag, ".remaining"}, 32'(bus.remaining), 32'(rem));
    chk({tag, ".tick"},      32'(bus.tick),      32'(tk));
    chk({tag, ".done"},      32'(bus.done),      32'(dn));
    chk({tag, ".busy"},      32'(bus.busy),      32'(bz));
  endtask

  // Start is sampled at the next edge ("edge 0"); returns just after it.
  task automatic start_pulse(input logic [CW-1:0] lv, input bit md);
    bus.start       = 1'b1;
    bus.load_val    = lv;
    bus.mode_reload = md;
    edges(1);
    bus.start       = 1'b0;
  endtask

  task automatic abort_pulse();
    bus.abort = 1'b1;
    edges(1);
    bus.abort = 1'b0;
  endtask

  initial begin
    int seen;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.mode_reload = 1'b0;
    bus.load_val    = '0;
`ifdef TIMER_PAUSE_EN
    bus.pause       = 1'b0;
`endif

    #12;
    chk_out("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    edges(1);

    // One-shot, 3 ticks
    start_pulse(4'd3, 1'b0);
    chk_out("os_e0", 3, 0, 0, 1);
    edges(9);  chk_out("os_e9",  3, 0, 0, 1);
    edges(1);  chk_out("os_e10", 2, 1, 0, 1);
    edges(1);  chk_out("os_e11", 2, 0, 0, 1);
    edges(9);  chk_out("os_e20", 1, 1, 0, 1);
    edges(10); chk_out("os_e30", 0, 1, 1, 0);
    edges(1);  chk_out("os_e31", 0, 0, 0, 0);

    // Auto-reload, 2 ticks
    start_pulse(4'd2, 1'b1);
    chk_out("ar_e0", 2, 0, 0, 1);
    edges(10); chk_out("ar_e10", 1, 1, 0, 1);
    edges(10); chk_out("ar_e20", 2, 1, 1, 1);
    edges(1);  chk_out("ar_e21", 2, 0, 0, 1);
    edges(19); chk_out("ar_e40", 2, 1, 1, 1);
    edges(20); chk_out("ar_e60", 2, 1, 1, 1);
    abort_pulse();
    chk_out("ar_abort", 0, 0, 0, 0);

    // Abort at edge 15
    start_pulse(4'd3, 1'b0);
    edges(14); chk_out("ab_e14", 2, 0, 0, 1);
    abort_pulse();
    chk_out("ab_e15", 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      edges(1);
      if (bus.tick || bus.done || bus.busy || bus.remaining != '0) seen++;
    end
    chk("ab_quiet", 32'(seen), 32'd0);

    // Restart at edge 25
    start_pulse(4'd3, 1'b0);
    edges(24); chk_out("rs_e24", 1, 0, 0, 1);
    start_pulse(4'd3, 1'b0);
    chk_out("rs_e25", 3, 0, 0, 1);
    edges(9);  chk_out("rs_e34", 3, 0, 0, 1);
    edges(1);  chk_out("rs_e35", 2, 1, 0, 1);
    abort_pulse();

    // Restart coinciding with a tick suppresses that tick
    start_pulse(4'd2, 1'b0);
    edges(9);
    start_pulse(4'd5, 1'b0);
    chk_out("st_e10", 5, 0, 0, 1);
    edges(10); chk_out("st_e20", 4, 1, 0, 1);
    abort_pulse();

    // Abort on the terminal cycle wins over tick/done
    start_pulse(4'd1, 1'b0);
    edges(9);
    abort_pulse();
    chk_out("abt_e10", 0, 0, 0, 0);
    edges(1);  chk_out("abt_e11", 0, 0, 0, 0);

    // Zero load from IDLE and from RUN
    start_pulse(4'd0, 1'b0);
    chk_out("z_idle", 0, 0, 1, 0);
    edges(1);  chk_out("z_idle_n", 0, 0, 0, 0);
    start_pulse(4'd3, 1'b1);
    edges(4);
    start_pulse(4'd0, 1'b0);
    chk_out("z_run", 0, 0, 1, 0);
    edges(1);  chk_out("z_run_n", 0, 0, 0, 0);

`ifdef TIMER_PAUSE_EN
    // Pause sampled at edges 5..14 of a 1-tick run
    start_pulse(4'd1, 1'b0);
    edges(4);
    bus.pause = 1'b1;
    edges(6);  chk_out("p_e10", 1, 0, 0, 1);
    edges(4);  chk_out("p_e14", 1, 0, 0, 1);
    bus.pause = 1'b0;
    edges(5);  chk_out("p_e19", 1, 0, 0, 1);
    edges(1);  chk_out("p_e20", 0, 1, 1, 0);
    edges(1);
`endif

    // Asynchronous reset mid-RUN, between edges
    start_pulse(4'd3, 1'b0);
    edges(12); chk_out("ar_pre", 2, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    edges(1);
    reset_n = 1'b1;
    edges(1);  chk_out("post_rst", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Parametrised successor of the team's fixed-period delay pulse generator.
- Divides CLOCK_50 into a programmable tick and counts down a loaded number of ticks.
- Reports ticks left, e.g. the serve countdown shown on the 7-segment displays.
- Emits a completion pulse; supports one-shot and auto-reload modes.
- Sits between game FSM (start/abort) and score/display logic (remaining, done).

Parameters:
- TICK_CYCLES, 50_000_000, CLOCK_50 cycles per tick (1 s at 50 MHz); legal range 2..2^26.
- CNT_W, 4, width of load value and remaining count.
- PRESC_W (localparam), $clog2(TICK_CYCLES), prescaler width; not overridable.

Ports:
- CLOCK_50  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; latches load_val/mode_reload, (re)starts countdown.
- abort  input  1  one-cycle request; stop, return to IDLE.
- mode_reload  input  1  0 = one-shot, 1 = auto-reload; sampled only with start.
- load_val  input  CNT_W  tick count to run; sampled only with start.
- remaining  output  CNT_W  ticks left in current period (registered).
- tick  output  1  one-cycle pulse per elapsed tick while running.
- done  output  1  one-cycle pulse when remaining reaches 0.
- busy  output  1  high in RUN state.
- pause  input  1  hold countdown (only with TIMER_PAUSE_EN).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, prescaler=0, remaining=0, reload reg=0, mode reg=0, tick=0, done=0, busy=0. Release is synchronous to the next edge.
- States:
  - IDLE: start with load_val!=0 -> RUN; prescaler=0, remaining=load_val, reload reg=load_val, mode reg=mode_reload, busy=1 at that edge.
  - IDLE: start with load_val==0 -> stay IDLE; done=1 for one cycle at that edge; tick stays 0.
  - RUN: prescaler increments each cycle. At prescaler==TICK_CYCLES-1: prescaler=0, tick=1, remaining-=1.
    - If remaining was 1, done=1 in the same cycle as tick.
    - One-shot: -> IDLE, remaining=0, busy=0.
    - Auto-reload: stay RUN, remaining=reload reg instead of 0.
- Latency: start sampled at edge k; first tick and decrement at edge k+TICK_CYCLES.
- In one-shot mode, done occurs at edge k+load_val*TICK_CYCLES.
- Priority (same cycle): abort > start > tick.
  - abort in RUN: -> IDLE, remaining=0, prescaler=0, no tick/done, even on the terminal cycle.
  - abort in IDLE: no effect.
  - start in RUN (no abort): full restart as from IDLE; any coinciding tick/done is suppressed.
- tick and done are registered pulses, never high more than one cycle per event. Both are 0 in IDLE except the load_val==0 done.
- Prescaler compare is an exact equality on PRESC_W bits; it never exceeds TICK_CYCLES-1. remaining never wraps below 0.
- Inputs are assumed synchronous to CLOCK_50; no internal synchronisers.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Defined:
  - pause port exists; pause=1 in RUN freezes prescaler and remaining; tick/done stay 0.
  - abort and start still act while paused; pause has no effect in IDLE.
  - Releasing pause resumes from the frozen prescaler value; no cycles are lost or added.
- Undefined: pause port absent; counting never stalls.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN).
  - default TICK_CYCLES constant for 50 MHz 1 s.
  - simulation constant SIM_TICK_CYCLES=10.
- One natural sub-module: tick_prescaler (free-running, clearable, enable-gated divide-by-TICK_CYCLES producing a single-cycle wrap strobe). The top FSM owns remaining/done.

Test Plan:
- TICK_CYCLES=10, CNT_W=4. Reset, then start with load_val=3, mode_reload=0 at edge 0:
  - tick at edges 10, 20, 30; remaining 3->2->1->0.
  - done and busy falling at edge 30.
- Auto-reload, load_val=2: done at edges 20, 40, 60; remaining reloads to 2 after each; busy stays 1.
- Abort and restart:
  - abort at edge 15 of a 3-tick run -> remaining=0, busy=0, no further tick/done.
  - start at edge 25 of a 3-tick run -> next tick at edge 35, remaining=2.
- Boundaries:
  - start with load_val=0 -> one done pulse, busy stays 0.
  - Assert reset_n=0 asynchronously mid-RUN -> all outputs 0 immediately, without a clock edge.
- TIMER_PAUSE_EN defined: pause high for edges 5..14 of a 1-tick run -> tick/done at edge 20 instead of 10.
